// File: rtl/tiger_pad_ctrl.sv
// Tiger message front-end: absorbs 64-bit words, applies Tiger v1 padding, and
// sequences 512-bit blocks through the compression core while chaining the 192-bit state.
module tiger_pad_ctrl (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_init,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [63:0]  i_data,
    input  logic         i_last,
    input  logic [3:0]   i_keep,
    output logic [511:0] o_blk,
    output logic [191:0] o_vin,
    output logic         o_start,
    input  logic [191:0] i_vout,
    input  logic         i_done,
    output logic [191:0] o_hash,
    output logic         o_hash_valid,
    output logic [2:0]   o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PAD    = 3'd2,
        ST_HASH   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [191:0] TIGER_IV = {64'hEFCDAB8967452301,
                                         64'h1032547698BADCFE,
                                         64'h87E1B2C3B4A596F0};

    // Handshake: a word transfers on a rising edge where i_valid && o_ready;
    // o_start is a one-cycle request and the block/chaining value hold until i_done.
    state_t       state;
    logic [63:0]  byte_cnt;
    logic [2:0]   idx;
    logic [6:0]   blk_bytes;
    logic         fin;
    logic         ext;
    logic         ext_one;

    logic [3:0]   keep_eff;
    logic         accept;
    logic [63:0]  bit_len;
    logic [511:0] pad_blk;
    logic [511:0] ext_blk;

    function automatic logic [63:0] swap64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = x[56-8*i +: 8];
        end
        return r;
    endfunction

    assign o_dbg_state = state;

    always_comb begin
        keep_eff = 4'd8;
        if (i_last) begin
            keep_eff = (i_keep > 4'd8) ? 4'd8 : i_keep;
        end
        accept  = (state == ST_ABSORB) && i_valid && o_ready;
        bit_len = byte_cnt << 3;

        // blk_bytes == 64 means the data filled the block; padding then moves
        // entirely into the extra block, which starts with the 0x01 marker.
        pad_blk = o_blk;
        for (int b = 0; b < 64; b++) begin
            if (7'(b) > blk_bytes) begin
                pad_blk[511-8*b -: 8] = 8'h00;
            end else if (7'(b) == blk_bytes) begin
                pad_blk[511-8*b -: 8] = 8'h01;
            end
        end
        if (blk_bytes <= 7'd55) begin
            pad_blk[63:0] = swap64(bit_len);
        end

        ext_blk = {(ext_one ? 8'h01 : 8'h00), 440'd0, swap64(bit_len)};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            idx          <= '0;
            blk_bytes    <= '0;
            fin          <= 1'b0;
            ext          <= 1'b0;
            ext_one      <= 1'b0;
            o_ready      <= 1'b0;
            o_blk        <= '0;
            o_vin        <= '0;
            o_start      <= 1'b0;
            o_hash       <= '0;
            o_hash_valid <= 1'b0;
        end else begin
            o_start      <= 1'b0;
            o_hash_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_init) begin
                        o_vin    <= TIGER_IV;
                        byte_cnt <= '0;
                        idx      <= '0;
                        fin      <= 1'b0;
                        ext      <= 1'b0;
                        ext_one  <= 1'b0;
                        o_hash   <= '0;
                        o_ready  <= 1'b1;
                        state    <= ST_ABSORB;
                    end
                end

                ST_ABSORB: begin
                    if (accept) begin
                        o_blk[{~idx, 6'd0} +: 64] <= i_data;
                        byte_cnt <= byte_cnt + 64'(keep_eff);
                        idx      <= idx + 3'd1;
                        if (i_last) begin
                            blk_bytes <= {1'b0, idx, 3'b000} + 7'(keep_eff);
                            o_ready   <= 1'b0;
                            state     <= ST_PAD;
                        end else if (idx == 3'd7) begin
                            fin     <= 1'b0;
                            o_ready <= 1'b0;
                            o_start <= 1'b1;
                            state   <= ST_HASH;
                        end
                    end
                end

                ST_PAD: begin
                    o_blk <= pad_blk;
                    if (blk_bytes <= 7'd55) begin
                        fin <= 1'b1;
                    end else begin
                        fin     <= 1'b0;
                        ext     <= 1'b1;
                        ext_one <= (blk_bytes == 7'd64);
                    end
                    o_start <= 1'b1;
                    state   <= ST_HASH;
                end

                ST_HASH: begin
                    // A completion cannot belong to a block issued this very cycle.
                    if (i_done && !o_start) begin
                        o_vin <= i_vout;
                        if (fin) begin
                            state <= ST_DONE;
                        end else if (ext) begin
                            o_blk   <= ext_blk;
                            ext     <= 1'b0;
                            fin     <= 1'b1;
                            o_start <= 1'b1;
                        end else begin
                            idx     <= '0;
                            o_ready <= 1'b1;
                            state   <= ST_ABSORB;
                        end
                    end
                end

                ST_DONE: begin
                    o_hash       <= o_vin;
                    o_hash_valid <= 1'b1;
                    state        <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
